// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder/subtractor.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_CHUNK = 4;
    localparam int NCHUNK    = DEF_WIDTH / DEF_CHUNK;

    // Chunk index width; never zero so the degenerate single-chunk case still has a register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_rca.sv
// CHUNK-bit ripple-carry slice built from one-bit full-adder cells; also exposes the
// carry into its MSB so the top can derive signed overflow.
module oneb_FA (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module chunk_rca
    import seq_chunk_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb_in
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    genvar i;
    generate
        for (i = 0; i < CHUNK; i++) begin : g_fa
            oneb_FA u_fa (
                .i_a   (i_a[i]),
                .i_b   (i_b[i]),
                .i_cin (w_c[i]),
                .o_s   (o_sum[i]),
                .o_cout(w_c[i+1])
            );
        end
    endgenerate

    assign o_cout     = w_c[CHUNK];
    assign o_c_msb_in = w_c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice reused NCHUNK times with a registered
// carry, behind a valid/ready handshake on both sides.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);
    localparam int LP_NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W     = calc_idx_w(LP_NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LP_NCHUNK - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH:0]   r_sum;
    logic             r_ovf;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_slice_cmsb;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_sum_next;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_last    = (r_idx == LAST_IDX);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < LP_NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_chunk = r_op_a[k*CHUNK +: CHUNK];
                w_b_chunk = r_op_b[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_rca #(.CHUNK(CHUNK)) u_slice (
        .i_a       (w_a_chunk),
        .i_b       (w_b_chunk),
        .i_cin     (r_carry),
        .o_sum     (w_slice_sum),
        .o_cout    (w_slice_cout),
        .o_c_msb_in(w_slice_cmsb)
    );

    // The old result is dropped on the first RUN edge rather than at accept, so it stays visible through IDLE.
    always_comb begin
        w_sum_next = (r_idx == '0) ? '0 : r_sum;
        for (int k = 0; k < LP_NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sum_next[k*CHUNK +: CHUNK] = w_slice_sum;
            end
        end
        if (w_last) begin
            w_sum_next[WIDTH] = w_slice_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_next;
            r_carry <= w_slice_cout;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_ovf <= w_slice_cmsb ^ w_slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed vector table and corner sequences on the 12/4 configuration, plus a random
// sweep over several WIDTH/CHUNK pairs checked against an arithmetic reference.
module tb_seq_chunk_adder;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        sub;
        logic [12:0] expSum;
        logic        expOvf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [11:0] a;
    logic [11:0] b;
    logic        sub;
    logic        outValid;
    logic        outReady;
    logic [12:0] sum;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    vec_t vecs [12];

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(12), .CHUNK(4)) uDut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .in_ready (inReady),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(outValid),
        .out_ready(outReady),
        .sum      (sum),
        .ovf      (ovf)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic markDone();
        doneCount++;
    endtask

    // One full transaction with out_ready held high; returns result and accept-to-valid latency.
    task automatic applyStimulus(input logic [11:0] aIn, input logic [11:0] bIn, input logic subIn,
                                 output logic [12:0] sumOut, output logic ovfOut, output int lat);
        int guard;
        @(negedge clk);
        a = aIn;
        b = bIn;
        sub = subIn;
        inValid = 1'b1;
        outReady = 1'b1;
        guard = 0;
        while (!inReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("acceptTimeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        sumOut = sum;
        ovfOut = ovf;
        @(posedge clk);
        #1 checkOutput("oneCycleValid", 64'(outValid), 64'd0);
    endtask

    function automatic int sweepWidth(input int g);
        case (g)
            0: return 8;
            1: return 8;
            2: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int sweepChunk(input int g);
        case (g)
            0: return 1;
            1: return 8;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gSweep
            localparam int W = sweepWidth(g);
            localparam int C = sweepChunk(g);
            localparam int N = W / C;

            logic         sRst;
            logic         sInValid;
            logic         sInReady;
            logic [W-1:0] sA;
            logic [W-1:0] sB;
            logic         sSub;
            logic         sOutValid;
            logic         sOutReady;
            logic [W:0]   sSum;
            logic         sOvf;

            seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) uSweep (
                .clk      (clk),
                .rst      (sRst),
                .in_valid (sInValid),
                .in_ready (sInReady),
                .a        (sA),
                .b        (sB),
                .sub      (sSub),
                .out_valid(sOutValid),
                .out_ready(sOutReady),
                .sum      (sSum),
                .ovf      (sOvf)
            );

            initial begin
                logic [W:0] expSum;
                logic       expOvf;
                int         lat;
                int         stall;
                sRst = 1'b1;
                sInValid = 1'b0;
                sA = '0;
                sB = '0;
                sSub = 1'b0;
                sOutReady = 1'b0;
                repeat (2) @(posedge clk);
                #1 sRst = 1'b0;
                for (int n = 0; n < 250; n++) begin
                    sA = W'($urandom);
                    sB = W'($urandom);
                    sSub = 1'($urandom_range(0, 1));
                    sOutReady = 1'($urandom_range(0, 1));
                    if (!sSub) begin
                        expSum = {1'b0, sA} + {1'b0, sB};
                        expOvf = (sA[W-1] == sB[W-1]) && (expSum[W-1] != sA[W-1]);
                    end else begin
                        expSum = {(sA >= sB), W'(sA - sB)};
                        expOvf = (sA[W-1] != sB[W-1]) && (expSum[W-1] != sA[W-1]);
                    end
                    checkOutput("sweepIdleReady", 64'(sInReady), 64'd1);
                    sInValid = 1'b1;
                    @(posedge clk);
                    #1 sInValid = 1'b0;
                    lat = 0;
                    while (!sOutValid && lat < 100) begin
                        @(posedge clk);
                        #1;
                        lat++;
                    end
                    checkOutput("sweepLatency", 64'(lat), 64'(N));
                    checkOutput("sweepSum", 64'(sSum), 64'(expSum));
                    checkOutput("sweepOvf", 64'(sOvf), 64'(expOvf));
                    if (sOutReady) begin
                        @(posedge clk);
                        #1 checkOutput("sweepOneCycle", 64'(sOutValid), 64'd0);
                    end else begin
                        stall = $urandom_range(0, 3);
                        repeat (stall) begin
                            @(posedge clk);
                            #1 checkOutput("sweepHold", 64'(sSum), 64'(expSum));
                        end
                        sOutReady = 1'b1;
                        @(posedge clk);
                        #1 sOutReady = 1'b0;
                    end
                end
                markDone();
            end
        end
    endgenerate

    initial begin
        logic [12:0] gotSum;
        logic        gotOvf;
        int          lat;
        int          guard;
        logic        sawValid;

        vecs[0]  = '{12'hFFF, 12'h001, 1'b0, 13'h1000, 1'b0};
        vecs[1]  = '{12'h005, 12'h007, 1'b1, 13'h0FFE, 1'b0};
        vecs[2]  = '{12'h007, 12'h005, 1'b1, 13'h1002, 1'b0};
        vecs[3]  = '{12'h7FF, 12'h001, 1'b0, 13'h0800, 1'b1};
        vecs[4]  = '{12'h800, 12'h001, 1'b1, 13'h17FF, 1'b1};
        vecs[5]  = '{12'h123, 12'h456, 1'b0, 13'h0579, 1'b0};
        vecs[6]  = '{12'h000, 12'h000, 1'b1, 13'h1000, 1'b0};
        vecs[7]  = '{12'h800, 12'h800, 1'b0, 13'h1000, 1'b1};
        vecs[8]  = '{12'hFFF, 12'hFFF, 1'b0, 13'h1FFE, 1'b0};
        vecs[9]  = '{12'h000, 12'h800, 1'b1, 13'h0800, 1'b1};
        vecs[10] = '{12'hABC, 12'hABC, 1'b1, 13'h1000, 1'b0};
        vecs[11] = '{12'h5A5, 12'hA5A, 1'b0, 13'h0FFF, 1'b0};

        rst = 1'b1;
        inValid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("resetInReady", 64'(inReady), 64'd1);
        checkOutput("resetOutValid", 64'(outValid), 64'd0);
        checkOutput("resetSum", 64'(sum), 64'd0);
        checkOutput("resetOvf", 64'(ovf), 64'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, gotSum, gotOvf, lat);
            checkOutput($sformatf("vec%0dSum", i), 64'(gotSum), 64'(vecs[i].expSum));
            checkOutput($sformatf("vec%0dOvf", i), 64'(gotOvf), 64'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0dLatency", i), 64'(lat), 64'd3);
        end

        // Backpressure: result must hold while the producer side thrashes.
        @(negedge clk);
        a = 12'h3C0;
        b = 12'h045;
        sub = 1'b0;
        inValid = 1'b1;
        outReady = 1'b0;
        @(posedge clk);
        #1 inValid = 1'b0;
        guard = 0;
        while (!outValid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("bpSum", 64'(sum), 64'h405);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inValid = ~inValid;
            a = 12'($urandom);
            b = 12'($urandom);
            sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("bpOutValid", 64'(outValid), 64'd1);
            checkOutput("bpInReady", 64'(inReady), 64'd0);
            checkOutput("bpSumHold", 64'(sum), 64'h405);
            checkOutput("bpOvfHold", 64'(ovf), 64'd0);
        end
        @(negedge clk);
        a = 12'h111;
        b = 12'h222;
        sub = 1'b0;
        inValid = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpHandshakeOutValid", 64'(outValid), 64'd0);
        checkOutput("bpHandshakeInReady", 64'(inReady), 64'd1);
        checkOutput("bpSumInIdle", 64'(sum), 64'h405);
        @(posedge clk);
        #1 inValid = 1'b0;
        checkOutput("bpNextAccepted", 64'(inReady), 64'd0);
        lat = 0;
        while (!outValid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bpNextLatency", 64'(lat), 64'd3);
        checkOutput("bpNextSum", 64'(sum), 64'h333);
        @(posedge clk);
        #1;

        // Reset on the edge after chunk 1 drops the transaction.
        @(negedge clk);
        a = 12'hFFF;
        b = 12'hFFF;
        sub = 1'b0;
        inValid = 1'b1;
        outReady = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("midRstInReady", 64'(inReady), 64'd1);
        checkOutput("midRstOutValid", 64'(outValid), 64'd0);
        checkOutput("midRstSum", 64'(sum), 64'd0);
        sawValid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("midRstNoPulse", 64'(sawValid), 64'd0);
        applyStimulus(12'h123, 12'h456, 1'b0, gotSum, gotOvf, lat);
        checkOutput("postRstSum", 64'(gotSum), 64'h0579);
        checkOutput("postRstLatency", 64'(lat), 64'd3);

        guard = 0;
        while (doneCount < 4 && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        if (doneCount < 4) checkOutput("sweepTimeout", 64'(doneCount), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
